// File: rtl/rr_arbiter_n.sv
// rtl/rr_arbiter_n.sv - round-robin arbiter holding the priority pointer, one-hot grant
module rr_arbiter_n #(
  parameter int N_CH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req,
  input  logic            advance,
  output logic [N_CH-1:0] grant
);

  localparam int SEL_W = $clog2(N_CH);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [N_CH-1:0]  req_rot;
  logic [N_CH-1:0]  gnt_rot;

  // Rotate requests so ptr sits at bit 0, isolate the lowest set bit, rotate the grant back
  always_comb begin
    req_rot = N_CH'({req, req} >> ptr_q);
    gnt_rot = req_rot & (~req_rot + N_CH'(1));
    grant   = N_CH'(({gnt_rot, gnt_rot} << ptr_q) >> N_CH);
  end

  // After a served grant the pointer moves just past the winner, wrapping to 0
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      for (int k = 0; k < N_CH; k++) begin
        if (grant[k]) begin
          ptr_d = (k == N_CH - 1) ? '0 : SEL_W'(k + 1);
        end
      end
    end
  end

  // Pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mux_n_to_1_rr.sv
// rtl/mux_n_to_1_rr.sv - N-to-1 stream mux, manual or round-robin select, registered output
module mux_n_to_1_rr #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH*DATA_W-1:0] in_data,
  output logic [N_CH-1:0]        in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_ch,
  input  logic                   out_ready
);

  localparam logic [SEL_W:0] N_CH_W = (SEL_W + 1)'(N_CH);

  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_ch_q, out_ch_d;

  logic                load;
  logic [N_CH-1:0]     rr_grant;
  logic [N_CH-1:0]     man_grant;
  logic [N_CH-1:0]     grant;
  logic [N_CH-1:0]     xfer_vec;
  logic                xfer;
  logic [DATA_W-1:0]   sel_data;
  logic [SEL_W-1:0]    sel_ch;

  rr_arbiter_n #(
    .N_CH (N_CH)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (in_valid),
    .advance (mode & xfer),
    .grant   (rr_grant)
  );

  // Grant selection; manual select ignores in_valid and drops out-of-range sel
  always_comb begin
    load      = !out_valid_q || out_ready;
    man_grant = '0;
    if ({1'b0, sel} < N_CH_W) begin
      man_grant[sel] = 1'b1;
    end
    grant    = mode ? rr_grant : man_grant;
    in_ready = rst ? '0 : (grant & {N_CH{load}});
    xfer_vec = in_valid & in_ready;
    xfer     = |xfer_vec;
  end

  // AND-OR data and channel-id select driven by the (at most one-hot) transfer vector
  always_comb begin
    sel_data = '0;
    sel_ch   = '0;
    for (int k = 0; k < N_CH; k++) begin
      sel_data = sel_data | (in_data[k*DATA_W +: DATA_W] & {DATA_W{xfer_vec[k]}});
      if (xfer_vec[k]) begin
        sel_ch = sel_ch | SEL_W'(k);
      end
    end
  end

  // Output stage: reload whenever empty or being consumed, otherwise hold the beat
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (load) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = sel_data;
        out_ch_d   = sel_ch;
      end
    end
  end

  // Output register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: doc/mux_n_to_1_rr.md
Name: mux_n_to_1_rr

Overview:
Parametrised N-channel, W-bit multiplexer with a registered output stage and a valid/ready handshake on every port.
- Channel choice comes either from an external select (manual mode) or from a round-robin arbiter over requesting channels.
- Sits between several producer streams and one consumer; sustains one beat per cycle.

Parameters:
N_CH, 4, number of input channels (>=2)
DATA_W, 8, data width per channel
SEL_W, $clog2(N_CH), select / channel-id width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
mode  input  1  0 = manual select, 1 = round-robin
sel  input  SEL_W  channel select, used in manual mode only
in_valid  input  N_CH  per-channel data valid
in_data  input  N_CH*DATA_W  packed channel data; channel k occupies bits [k*DATA_W +: DATA_W]
in_ready  output  N_CH  per-channel accept, combinational
out_valid  output  1  registered output beat valid
out_data  output  DATA_W  registered output data
out_ch  output  SEL_W  id of the channel that produced out_data
out_ready  input  1  consumer accept

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_ch=0, round-robin pointer ptr=0.
  - in_ready=0 while rst is high.
  - Reset mid-transfer discards any held beat.
- Load enable: load = !out_valid | out_ready. Requires a single output register; no bubbles when the consumer is always ready.
- Grant, combinational, at most one-hot:
  - Manual mode: grant = onehot(sel) if sel < N_CH, else no grant.
  - Round-robin mode: grant = first k with in_valid[k]=1, scanning ptr, ptr+1, ..., wrapping modulo N_CH.
  - If no channel is valid, no grant.
- in_ready = grant & {N_CH{load}}:
  - Manual mode asserts in_ready[sel] even if in_valid[sel]=0.
  - Round-robin mode asserts it only on a valid channel.
- Transfer on channel k when in_valid[k] & in_ready[k]. At the next edge: out_valid=1, out_data=in_data[k], out_ch=k. Latency is 1 cycle.
- If load=1 and no transfer occurs, out_valid goes to 0 at the next edge (the beat was consumed, nothing replaces it).
- If load=0, the output holds out_valid, out_data and out_ch stable. Producers must see in_ready=0.
- Pointer:
  - On a round-robin transfer from k, ptr <= (k+1) mod N_CH, wrapping from N_CH-1 to 0.
  - ptr is unchanged in manual mode and on cycles with no transfer.
- Fairness: with all channels continuously valid and out_ready=1, grants rotate 0,1,..,N_CH-1,0,...
- Mode or sel changes take effect combinationally for the current arbitration. An already-registered beat is unaffected.
- Simultaneous output consume and new accept in the same cycle is legal and gives full throughput.
- Out-of-range sel (non-power-of-2 N_CH) produces no grant, so no data is lost or corrupted.
- Inputs are not required to hold in_valid once asserted. A valid dropped before a grant is ignored.

Decomposition:
- No shared package is needed. Channel-id width is derived locally.
- One sub-module is natural: rr_arbiter_n. It holds ptr and computes the one-hot grant from a request vector, using the double-width request rotate-and-mask technique.
- The top level handles mode muxing, the data-select AND-OR tree and the output register.

Test Plan:
- Reset: assert rst with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, out_ch=0 on the next cycle; deassert -> first round-robin grant is ch0.
- Manual mode: mode=0, sel=2, in_data ch2=8'hA5, in_valid=4'b0100, out_ready=1 -> next cycle out_valid=1, out_data=8'hA5, out_ch=2. Set in_valid=4'b1011 -> no transfer, out_valid drops to 0.
- Round-robin rotation: mode=1, all valid with ch k data=8'h10+k, out_ready=1 for 6 cycles -> out_ch sequence 0,1,2,3,0,1 with matching data 8'h10..8'h13.
- Sparse requests with wrap: ptr=3 after a grant of ch2, in_valid=4'b0010 -> grant ch1, ptr becomes 2. Then in_valid=4'b1001 -> grant ch3, ptr becomes 0.
- Backpressure: out_valid=1 holding out_data=8'h42, out_ready=0 for 3 cycles -> in_ready=0 and out_data/out_ch stable throughout. out_ready=1 -> the new beat loads in the same cycle.
- Mid-stream reset and mode switch: rst pulse while out_valid=1 -> out_valid=0 next cycle and ptr=0. A mode 1->0 switch with sel=1 -> the next beat comes from ch1 regardless of ptr.
